// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory port arbiter.
package dmem_pkg;

  localparam int DM_IDX_W = 7;

  typedef enum logic {
    CPU_OWN = 1'b0,
    DBG_OWN = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_tag_e;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage and the debug/loader port.
// CPU has priority, debug may lock the port for bursts, starvation forces a debug slot.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   CPU_OWN | CPU has priority; debug served when idle or when starved
//   DBG_OWN | debug holds the port for a locked burst; CPU requests stall
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IDX_W      = DM_IDX_W,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [IDX_W-1:0]  dbg_idx,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_idx,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              misalign
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e        state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_force;
  logic              cpu_grant, dbg_grant;
  logic [IDX_W-1:0]  cpu_idx;
  logic              rd_pend;
  owner_tag_e        rd_owner;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              unused_addr;

  // Word index wraps modulo the memory depth; high address bits are ignored.
  assign cpu_idx     = cpu_addr[IDX_W+1:2];
  assign unused_addr = ^{cpu_addr[31:IDX_W+2]};

  assign starve_force = (starve_cnt == CNT_W'(STARVE_MAX)) && dbg_req;

  always_comb begin
    state_nxt = state;
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    case (state)
      CPU_OWN: begin
        if (cpu_req && !starve_force) begin
          cpu_grant = 1'b1;
        end else if (dbg_req) begin
          dbg_grant = 1'b1;
        end
        if (dbg_grant && dbg_lock) begin
          state_nxt = DBG_OWN;
        end
      end
      DBG_OWN: begin
        dbg_grant = dbg_req;
        if (!dbg_lock) begin
          state_nxt = CPU_OWN;
        end
      end
      default: state_nxt = CPU_OWN;
    endcase
  end

  assign cpu_stall = cpu_req && !cpu_grant;
  assign dbg_gnt   = dbg_grant;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_wdata = '0;
    if (cpu_grant) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_idx   = cpu_idx;
      mem_wdata = cpu_wdata;
    end else if (dbg_grant) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_idx   = dbg_idx;
      mem_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CPU_OWN;
      starve_cnt <= '0;
      misalign   <= 1'b0;
      rd_pend    <= 1'b0;
      rd_owner   <= OWN_CPU;
    end else begin
      state <= state_nxt;
      if (!dbg_req || dbg_grant) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (cpu_grant && (cpu_addr[1:0] != 2'b00)) begin
        misalign <= 1'b1;
      end
      rd_pend  <= (cpu_grant && !cpu_we) || (dbg_grant && !dbg_we);
      rd_owner <= cpu_grant ? OWN_CPU : OWN_DBG;
    end
  end

  assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
  assign dbg_rvalid = rd_pend && (rd_owner == OWN_DBG);

  // Read data passes straight through in the response cycle and is held afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 128-word synchronous memory.
module tb_dmem_port_arbiter;

  logic        clk, rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [6:0]  dbg_idx;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [6:0]  mem_idx;
  logic [31:0] mem_wdata, mem_rdata;
  logic        misalign;

  logic [31:0] tb_mem [128];
  int          n_checks = 0;
  int          n_errors = 0;

  dmem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_idx    (dbg_idx),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_idx    (mem_idx),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 128; i++) tb_mem[i] = 32'h0;
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_idx] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_idx];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_idx = 0; dbg_wdata = 0; dbg_lock = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    tick(); tick();
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
    check("rst_dbg_gnt",    32'(dbg_gnt), 0);
    check("rst_mem_en",     32'(mem_en), 0);
    check("rst_misalign",   32'(misalign), 0);
    check("rst_state",      32'(dut.state), 0);
    rst = 1;
    tick();

    // sw 0x14 <- 0x2A, then lw 0x14
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h14; cpu_wdata = 32'h2A;
    #2;
    check("sw_mem_en",    32'(mem_en), 1);
    check("sw_mem_we",    32'(mem_we), 1);
    check("sw_mem_idx",   32'(mem_idx), 5);
    check("sw_mem_wdata", mem_wdata, 32'h2A);
    check("sw_stall",     32'(cpu_stall), 0);
    tick();
    cpu_we = 0;
    #2;
    check("lw_mem_idx", 32'(mem_idx), 5);
    check("lw_mem_we",  32'(mem_we), 0);
    tick();
    cpu_req = 0;
    #1;
    check("lw_rvalid", 32'(cpu_rvalid), 1);
    check("lw_rdata",  cpu_rdata, 32'h2A);
    tick();
    check("lw_rvalid_drop", 32'(cpu_rvalid), 0);
    check("lw_rdata_hold",  cpu_rdata, 32'h2A);

    // starvation: both request continuously
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
    dbg_req = 1; dbg_we = 0; dbg_idx = 7'd2;
    for (int i = 0; i < 8; i++) begin
      #2;
      check("starve_cpu_stall", 32'(cpu_stall), 0);
      check("starve_dbg_gnt",   32'(dbg_gnt), 0);
      if (i > 0) check("b2b_cpu_rvalid", 32'(cpu_rvalid), 1);
      tick();
    end
    #2;
    check("forced_dbg_gnt",   32'(dbg_gnt), 1);
    check("forced_cpu_stall", 32'(cpu_stall), 1);
    check("forced_mem_idx",   32'(mem_idx), 2);
    tick();
    check("forced_dbg_rvalid", 32'(dbg_rvalid), 1);
    check("forced_cpu_rvalid", 32'(cpu_rvalid), 0);
    #1;
    check("after_force_dbg_gnt", 32'(dbg_gnt), 0);
    check("after_force_stall",   32'(cpu_stall), 0);
    idle_inputs();
    tick(); tick();

    // locked debug burst write idx 0..3 while CPU requests
    dbg_req = 1; dbg_lock = 1; dbg_we = 1; dbg_idx = 7'd0; dbg_wdata = 32'h100;
    #2;
    check("burst0_dbg_gnt", 32'(dbg_gnt), 1);
    tick();
    check("burst_state", 32'(dut.state), 1);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
    for (int i = 1; i < 4; i++) begin
      dbg_idx = 7'(i); dbg_wdata = 32'h100 + 32'(i);
      #2;
      check("burst_cpu_stall", 32'(cpu_stall), 1);
      check("burst_dbg_gnt",   32'(dbg_gnt), 1);
      check("burst_mem_idx",   32'(mem_idx), 32'(i));
      tick();
    end
    dbg_req = 0; dbg_lock = 0; dbg_we = 0;
    #2;
    check("unlock_cycle_stall", 32'(cpu_stall), 1);
    tick();
    #1;
    check("released_stall",   32'(cpu_stall), 0);
    check("released_mem_idx", 32'(mem_idx), 2);
    tick();
    check("burst_cpu_rdata", cpu_rdata, 32'h102);
    cpu_req = 0;
    dbg_req = 1; dbg_we = 0; dbg_idx = 7'd3;
    tick();
    check("burst_dbg_rvalid", 32'(dbg_rvalid), 1);
    check("burst_dbg_rdata",  dbg_rdata, 32'h103);
    idle_inputs();
    tick();

    // misaligned load at 0x16 lands on idx 5
    check("pre_misalign", 32'(misalign), 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h16;
    #2;
    check("misalign_mem_idx", 32'(mem_idx), 5);
    tick();
    check("misalign_set",   32'(misalign), 1);
    check("misalign_rdata", cpu_rdata, 32'h2A);

    // wrap: 0x204 -> idx 1, read back through debug port
    cpu_we = 1; cpu_addr = 32'h204; cpu_wdata = 32'hDEADBEEF;
    #2;
    check("wrap_mem_idx", 32'(mem_idx), 1);
    tick();
    check("misalign_sticky", 32'(misalign), 1);
    cpu_req = 0; cpu_we = 0;
    dbg_req = 1; dbg_idx = 7'd1;
    tick();
    check("wrap_dbg_rvalid", 32'(dbg_rvalid), 1);
    check("wrap_dbg_rdata",  dbg_rdata, 32'hDEADBEEF);
    idle_inputs();
    tick();

    // reset during a CPU read grant cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h14;
    dbg_req = 1; dbg_idx = 7'd0;
    tick();
    check("pre_rst_starve", 32'(dut.starve_cnt), 1);
    check("pre_rst_rvalid", 32'(cpu_rvalid), 1);
    #1;
    rst = 0;
    #1;
    check("rst_async_rvalid", 32'(cpu_rvalid), 0);
    check("rst_async_starve", 32'(dut.starve_cnt), 0);
    tick();
    check("rst_mid_rvalid",   32'(cpu_rvalid), 0);
    check("rst_mid_state",    32'(dut.state), 0);
    check("rst_mid_misalign", 32'(misalign), 0);
    idle_inputs();
    rst = 1;
    tick();
    check("post_rst_rvalid", 32'(cpu_rvalid), 0);
    check("post_rst_dbg_rvalid", 32'(dbg_rvalid), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
